// File: rtl/router_local_injector_pkg.sv
// Shared router definitions: flit width default, port indices and the local
// injector state encoding.
package router_pkg;

    localparam int DEFAULT_FLIT_WIDTH = 32;
    localparam int NPORT              = 5;

    localparam int EAST  = 0;
    localparam int WEST  = 1;
    localparam int NORTH = 2;
    localparam int SOUTH = 3;
    localparam int LOCAL = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        SIZE    = 2'd2,
        PAYLOAD = 2'd3
    } inj_state_e;

endpackage

// File: rtl/router_local_injector_if.sv
// Core-side descriptor/payload handshakes plus the credit channel toward the
// router LOCAL input. The injector uses the slave view.
interface router_local_injector_if #(
    parameter int FLIT_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [FLIT_WIDTH-1:0] cmd_target;
    logic [FLIT_WIDTH-1:0] cmd_size;
    logic                  pl_valid;
    logic                  pl_ready;
    logic [FLIT_WIDTH-1:0] pl_data;
    logic                  tx;
    logic [FLIT_WIDTH-1:0] data_o;
    logic                  credit_i;

    modport master (
        output cmd_valid, cmd_target, cmd_size, pl_valid, pl_data, credit_i,
        input  cmd_ready, pl_ready, tx, data_o
    );

    modport slave (
        input  cmd_valid, cmd_target, cmd_size, pl_valid, pl_data, credit_i,
        output cmd_ready, pl_ready, tx, data_o
    );
endinterface

// File: rtl/router_local_injector_fifo.sv
// Synchronous payload FIFO; head is the oldest entry and shows a pushed word
// the cycle after the push.
module flit_fifo
    import router_pkg::*;
#(
    parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [FLIT_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [FLIT_WIDTH-1:0] head
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [FLIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == CNT_ZERO);
    assign head      = mem_q[rd_ptr_q];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset discards buffered words.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful while counted as occupied.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/router_local_injector.sv
// Local-port injector: serialises header, size and buffered payload flits
// onto the router rx channel under credit flow control.
module router_local_injector
    import router_pkg::*;
#(
    parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    router_local_injector_if.slave    io,
    output logic                      clock_tx,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      pkt_count
);
    localparam logic [FLIT_WIDTH-1:0] FLIT_ZERO = {FLIT_WIDTH{1'b0}};
    localparam logic [FLIT_WIDTH-1:0] FLIT_ONE  = FLIT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

    inj_state_e            state_q, state_d;
    logic [FLIT_WIDTH-1:0] target_q, target_d, size_q, size_d;
    logic [FLIT_WIDTH-1:0] in_rem_q, in_rem_d, out_rem_q, out_rem_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
    logic                  cmd_ready_q, cmd_ready_d;

    logic                  fifo_full_s, fifo_empty_s, fifo_pop_s;
    logic [FLIT_WIDTH-1:0] fifo_head_s;
    logic                  tx_s, pl_ready_s, cmd_fire_s, pl_fire_s, xfer_s;
    logic [FLIT_WIDTH-1:0] data_s;

    flit_fifo #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (pl_fire_s),
        .push_data (io.pl_data),
        .pop       (fifo_pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (fifo_head_s)
    );

    // Intake depends on registered state only, never on credit_i.
    assign pl_ready_s  = (in_rem_q != FLIT_ZERO) && !fifo_full_s;
    assign cmd_fire_s  = io.cmd_valid && cmd_ready_q;
    assign pl_fire_s   = io.pl_valid && pl_ready_s;
    assign xfer_s      = tx_s && io.credit_i;
    assign fifo_pop_s  = xfer_s && (state_q == PAYLOAD);
    assign cmd_ready_d = (state_d == IDLE);

    assign io.cmd_ready = cmd_ready_q;
    assign io.pl_ready  = pl_ready_s;
    assign io.tx        = tx_s;
    assign io.data_o    = data_s;
    assign clock_tx     = clock;
    assign busy         = (state_q != IDLE);
    assign pkt_count    = pkt_count_q;

    // Channel output decode from the current state and FIFO head.
    always_comb begin
        tx_s   = 1'b0;
        data_s = FLIT_ZERO;
        case (state_q)
            IDLE: begin
                tx_s   = 1'b0;
                data_s = FLIT_ZERO;
            end
            HEADER: begin
                tx_s   = 1'b1;
                data_s = target_q;
            end
            SIZE: begin
                tx_s   = 1'b1;
                data_s = size_q;
            end
            PAYLOAD: begin
                tx_s   = !fifo_empty_s;
                data_s = fifo_empty_s ? FLIT_ZERO : fifo_head_s;
            end
            default: begin
                tx_s   = 1'b0;
                data_s = FLIT_ZERO;
            end
        endcase
    end

    // Payload words still to be taken from the core for this packet.
    always_comb begin
        in_rem_d = in_rem_q;
        if (cmd_fire_s) begin
            in_rem_d = io.cmd_size;
        end else if (pl_fire_s) begin
            in_rem_d = in_rem_q - FLIT_ONE;
        end else begin
            in_rem_d = in_rem_q;
        end
    end

    // Packet sequencing and completion counting.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        size_d      = size_q;
        out_rem_d   = out_rem_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire_s) begin
                    state_d  = HEADER;
                    target_d = io.cmd_target;
                    size_d   = io.cmd_size;
                end else begin
                    state_d = IDLE;
                end
            end
            HEADER: begin
                if (xfer_s) begin
                    state_d = SIZE;
                end else begin
                    state_d = HEADER;
                end
            end
            SIZE: begin
                if (xfer_s && (size_q == FLIT_ZERO)) begin
                    state_d     = IDLE;
                    pkt_count_d = pkt_count_q + CNT_ONE;
                end else if (xfer_s) begin
                    state_d   = PAYLOAD;
                    out_rem_d = size_q;
                end else begin
                    state_d = SIZE;
                end
            end
            PAYLOAD: begin
                if (xfer_s && (out_rem_q == FLIT_ONE)) begin
                    state_d     = IDLE;
                    out_rem_d   = FLIT_ZERO;
                    pkt_count_d = pkt_count_q + CNT_ONE;
                end else if (xfer_s) begin
                    state_d   = PAYLOAD;
                    out_rem_d = out_rem_q - FLIT_ONE;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Injector state registers; a reset mid-packet abandons the packet.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= FLIT_ZERO;
            size_q      <= FLIT_ZERO;
            in_rem_q    <= FLIT_ZERO;
            out_rem_q   <= FLIT_ZERO;
            pkt_count_q <= {CNT_WIDTH{1'b0}};
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            size_q      <= size_d;
            in_rem_q    <= in_rem_d;
            out_rem_q   <= out_rem_d;
            pkt_count_q <= pkt_count_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

endmodule

// File: tb/tb_router_local_injector.sv
// Directed and randomized bench for router_local_injector; a flit-queue model
// predicts every channel and handshake output each cycle.
module tb_router_local_injector;
    import router_pkg::*;

    localparam int FW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          clock_tx, busy;
    logic [CW-1:0] pkt_count;

    router_local_injector_if #(.FLIT_WIDTH(FW)) bus ();

    router_local_injector #(
        .FLIT_WIDTH (FW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io        (bus),
        .clock_tx  (clock_tx),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fails = 0;

    // Stimulus sources and reference model state.
    logic [FW-1:0] cmd_t_q[$], cmd_s_q[$], pl_src[$], exp_q[$];
    bit            m_busy, m_fresh;
    int            m_pos, m_fifo, m_left, m_pl_left;
    logic [CW-1:0] m_count;
    int            cred_mode, pl_hold;
    bit            pl_rand, prev_hold, pl_ready_seen;
    logic [FW-1:0] prev_data;
    int            dut_xfer, dut_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        cmd_t_q.delete(); cmd_s_q.delete(); pl_src.delete(); exp_q.delete();
        m_busy = 1'b0; m_fresh = 1'b1; m_pos = 0; m_fifo = 0; m_left = 0;
        m_pl_left = 0; m_count = '0; prev_hold = 1'b0; pl_hold = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.pl_valid = 1'b0; bus.credit_i = 1'b0;
        bus.cmd_target = '0; bus.cmd_size = '0; bus.pl_data = '0;
        repeat (n) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic add_pkt(input logic [FW-1:0] tgt, input int size, input int npl);
        cmd_t_q.push_back(tgt);
        cmd_s_q.push_back(FW'(size));
        for (int i = 0; i < npl; i++) pl_src.push_back($urandom);
    endtask

    // One cycle: drive inputs, check every output against the model, advance.
    task automatic tick();
        bit            exp_tx, exp_cr, exp_pr, cmd_f, pl_f, xf;
        logic [FW-1:0] exp_data;
        bus.cmd_valid  = (cmd_t_q.size() != 0);
        bus.cmd_target = bus.cmd_valid ? cmd_t_q[0] : '0;
        bus.cmd_size   = bus.cmd_valid ? cmd_s_q[0] : '0;
        bus.pl_valid   = (pl_src.size() != 0) && (pl_hold == 0) &&
                         (!pl_rand || ($urandom_range(0, 3) != 0));
        bus.pl_data    = bus.pl_valid ? pl_src[0] : '0;
        case (cred_mode)
            0:       bus.credit_i = 1'b1;
            1:       bus.credit_i = 1'($urandom_range(0, 1));
            default: bus.credit_i = 1'b0;
        endcase
        #1;
        exp_tx   = m_busy && ((m_pos < 2) || (m_fifo > 0));
        exp_cr   = !m_busy && !m_fresh;
        exp_pr   = (m_pl_left != 0) && (m_fifo < DEPTH);
        exp_data = (exp_tx && exp_q.size() != 0) ? exp_q[0] : '0;
        chk("cmd_ready", bus.cmd_ready, exp_cr);
        chk("busy", busy, m_busy);
        chk("tx", bus.tx, exp_tx);
        chk("data_o", bus.data_o, exp_data);
        chk("pl_ready", bus.pl_ready, exp_pr);
        chk("pkt_count", pkt_count, m_count);
        if (prev_hold) begin
            chk("stall_tx", bus.tx, 1'b1);
            chk("stall_data", bus.data_o, prev_data);
        end
        if (bus.tx && bus.credit_i) dut_xfer++;
        if (bus.pl_valid && bus.pl_ready) dut_acc++;
        if (bus.pl_ready) pl_ready_seen = 1'b1;
        cmd_f = bus.cmd_valid && exp_cr;
        pl_f  = bus.pl_valid && exp_pr;
        xf    = exp_tx && bus.credit_i;
        if (xf) begin
            if (m_pos >= 2) m_fifo--;
            void'(exp_q.pop_front());
            m_pos++;
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_pos = 0; m_count = m_count + 1'b1;
            end
        end
        if (pl_f) begin
            exp_q.push_back(bus.pl_data);
            void'(pl_src.pop_front());
            m_fifo++;
            m_pl_left--;
        end
        if (cmd_f) begin
            exp_q.push_back(bus.cmd_target);
            exp_q.push_back(bus.cmd_size);
            m_busy = 1'b1; m_pos = 0;
            m_left = int'(bus.cmd_size) + 2;
            m_pl_left = int'(bus.cmd_size);
            void'(cmd_t_q.pop_front());
            void'(cmd_s_q.pop_front());
        end
        m_fresh   = 1'b0;
        prev_hold = exp_tx && !bus.credit_i;
        prev_data = bus.data_o;
        if (pl_hold > 0) pl_hold--;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while ((m_busy || cmd_t_q.size() != 0) && n < max) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(m_busy || cmd_t_q.size() != 0), 32'd0);
    endtask

    initial begin
        int x0, a0, n;
        logic [CW-1:0] c0;
        logic [FW-1:0] held;
        cred_mode = 0; pl_rand = 1'b0; dut_xfer = 0; dut_acc = 0; pl_ready_seen = 1'b0;
        do_reset(2);
        chk("clock_tx", 32'(clock_tx), 32'(clock));
        tick();
        chk("rst_pkt_count", pkt_count, 16'd0);

        // Basic packet: five back-to-back flits.
        cmd_t_q.push_back(32'h0000_0102); cmd_s_q.push_back(32'd3);
        pl_src.push_back(32'hA); pl_src.push_back(32'hB); pl_src.push_back(32'hC);
        tick();
        x0 = dut_xfer;
        repeat (5) tick();
        chk("t1_consecutive", 32'(dut_xfer - x0), 32'd5);
        chk("t1_pkt_count", pkt_count, 16'd1);
        chk("t1_busy", busy, 1'b0);
        tick();

        // Zero-size packet.
        pl_ready_seen = 1'b0;
        x0 = dut_xfer;
        add_pkt(32'h11, 0, 0);
        repeat (3) tick();
        chk("t2_flits", 32'(dut_xfer - x0), 32'd2);
        chk("t2_cmd_ready", bus.cmd_ready, 1'b1);
        chk("t2_pl_ready", pl_ready_seen, 1'b0);
        tick();

        // Credit stall on the second payload flit.
        add_pkt($urandom, 4, 4);
        n = 0;
        while (m_pos != 3 && n < 20) begin tick(); n++; end
        chk("t3_reach", 32'(m_pos), 32'd3);
        cred_mode = 2;
        held = bus.data_o;
        repeat (4) begin
            tick();
            chk("t3_hold_tx", bus.tx, 1'b1);
            chk("t3_hold_data", bus.data_o, held);
        end
        cred_mode = 0;
        run_until_idle(50);
        tick();

        // Backpressure: FIFO fills at DEPTH, 11th offered flit refused.
        add_pkt($urandom, 10, 11);
        cred_mode = 2;
        a0 = dut_acc;
        repeat (15) tick();
        chk("t4_accepts_full", 32'(dut_acc - a0), 32'(DEPTH));
        chk("t4_pl_ready_low", bus.pl_ready, 1'b0);
        cred_mode = 0;
        run_until_idle(100);
        repeat (3) tick();
        chk("t4_accepts_total", 32'(dut_acc - a0), 32'd10);
        chk("t4_extra_left", 32'(pl_src.size()), 32'd1);
        pl_src.delete();

        // Starvation: second payload flit arrives late.
        c0 = pkt_count;
        add_pkt($urandom, 3, 1);
        n = 0;
        while (m_pos != 3 && n < 20) begin tick(); n++; end
        repeat (5) begin
            tick();
            chk("t5_gap_tx", bus.tx, 1'b0);
            chk("t5_gap_count", pkt_count, c0);
        end
        pl_src.push_back($urandom); pl_src.push_back($urandom);
        run_until_idle(50);
        tick();
        chk("t5_count", pkt_count, c0 + 16'd1);

        // Reset during PAYLOAD with buffered flits.
        add_pkt($urandom, 5, 5);
        n = 0;
        while (m_pos != 2 && n < 20) begin tick(); n++; end
        cred_mode = 2;
        n = 0;
        while (m_fifo < 2 && n < 20) begin tick(); n++; end
        chk("t6_buffered", 32'(m_fifo >= 2), 32'd1);
        cred_mode = 0;
        do_reset(1);
        chk("t6_tx", bus.tx, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_count", pkt_count, 16'd0);
        tick();
        add_pkt($urandom, 1, 1);
        run_until_idle(50);
        tick();
        chk("t6_after", pkt_count, 16'd1);

        // Counter wrap.
        force dut.pkt_count_q = 16'hFFFF;
        #1;
        release dut.pkt_count_q;
        m_count = 16'hFFFF;
        add_pkt($urandom, 2, 2);
        run_until_idle(50);
        tick();
        chk("wrap", pkt_count, 16'd0);

        // Randomized traffic with random credit and payload gaps.
        cred_mode = 1; pl_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            n = $urandom_range(0, 9);
            add_pkt($urandom, n, n);
        end
        run_until_idle(3000);
        cred_mode = 0;
        repeat (2) tick();
        chk("rand_count", pkt_count, 16'd25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
